// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_INSTR_W = 32;
    localparam int INSTR_BYTES = DEF_INSTR_W / 8;

    function automatic int instr_bytes(input int instr_w);
        return instr_w / 8;
    endfunction

    // Default-width entry; the top re-declares it at its own parameter widths.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0]  pc;
        logic [DEF_INSTR_W-1:0] data;
    } buf_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - in-order fetch FIFO with clear, push, pop and occupancy count
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = buf_entry_t,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  entry_t           push_data,
    input  logic             pop,
    output entry_t           head,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

    // The issue credit guarantees a slot for every response.
    assert property (@(posedge clock) disable iff (!reset)
        !(push && !pop && !clear && count == CNT_W'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage; FETCH_PERF_EN adds stall/flush counters
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                INSTR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_req_addr,
    input  logic               mem_resp_valid,
    input  logic [INSTR_W-1:0] mem_resp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    localparam int                CNT_W  = $clog2(BUF_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(instr_bytes(INSTR_W));

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] data;
    } entry_t;

    fetch_state_t     state, next_state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  out_next;
    logic              credit_ok;
    logic              hs;
    logic              resp_fire;
    logic              push;
    logic              pop;
    entry_t            head;
    entry_t            push_entry;

    // Responses with nothing in flight cannot belong to any request.
    assign resp_fire  = mem_resp_valid && (outstanding != '0);
    assign hs         = mem_req_valid && mem_req_ready;
    assign out_next   = outstanding + CNT_W'(hs) - CNT_W'(resp_fire);
    assign credit_ok  = ((CNT_W+1)'(outstanding) + (CNT_W+1)'(count)) < (CNT_W+1)'(BUF_DEPTH);
    assign push       = resp_fire && (drop_cnt == '0) && !redirect_valid;
    assign pop        = instr_valid && instr_ready && !redirect_valid;
    assign push_entry = '{pc: resp_pc, data: mem_resp_data};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (redirect_valid) begin
            if (out_next != '0) next_state = FLUSH;
            else                next_state = fetch_en ? FETCH : IDLE;
        end else begin
            case (state)
                IDLE:    if (fetch_en) next_state = FETCH;
                FETCH:   if (!fetch_en && outstanding == '0) next_state = IDLE;
                FLUSH:   if (drop_cnt == '0 || (drop_cnt == CNT_W'(1) && resp_fire))
                             next_state = fetch_en ? FETCH : IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        mem_req_valid = (state == FETCH) && fetch_en && !redirect_valid && credit_ok;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= out_next;
            if (redirect_valid) begin
                pc       <= redirect_pc;
                resp_pc  <= redirect_pc;
                drop_cnt <= out_next;
            end else begin
                if (hs)   pc      <= pc + PC_INC;
                if (push) resp_pc <= resp_pc + PC_INC;
                if (resp_fire && drop_cnt != '0) drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    fetch_buffer #(
        .DEPTH   (BUF_DEPTH),
        .entry_t (entry_t)
    ) u_buf (
        .clock     (clock),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign mem_req_addr = pc;
    assign instr_valid  = (count != '0);
    assign instr_data   = instr_valid ? head.data : '0;
    assign instr_pc     = instr_valid ? head.pc : '0;

`ifdef FETCH_PERF_EN
    logic stall;
    assign stall = ((state == FETCH) && !mem_req_valid) || (mem_req_valid && !mem_req_ready);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall && perf_stall_cnt != '1)          perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redirect_valid && perf_flush_cnt != '1) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with queue-based reference model
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, fetch_en, redirect_valid, mem_req_valid, mem_req_ready;
    logic        mem_resp_valid, instr_valid, instr_ready;
    logic [31:0] redirect_pc, mem_req_addr, mem_resp_data, instr_data, instr_pc;

    logic        w_reset, w_fetch_en, w_mem_req_valid, w_mem_req_ready, w_instr_valid;
    logic [31:0] w_mem_req_addr, w_instr_data, w_instr_pc;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt, w_perf_stall_cnt, w_perf_flush_cnt;
`endif

    fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_data(instr_data), .instr_pc(instr_pc)
`ifdef FETCH_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(DEPTH)) dut_wrap (
        .clock(clock), .reset(w_reset), .fetch_en(w_fetch_en),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .mem_req_valid(w_mem_req_valid), .mem_req_ready(w_mem_req_ready), .mem_req_addr(w_mem_req_addr),
        .mem_resp_valid(1'b0), .mem_resp_data(32'h0),
        .instr_valid(w_instr_valid), .instr_ready(1'b0),
        .instr_data(w_instr_data), .instr_pc(w_instr_pc)
`ifdef FETCH_PERF_EN
        , .perf_stall_cnt(w_perf_stall_cnt), .perf_flush_cnt(w_perf_flush_cnt)
`endif
    );

    typedef struct { logic [31:0] addr; bit stale; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } be_t;
    typedef enum { M_IDLE, M_FETCH, M_FLUSH } mode_t;

    fl_t         inflight[$];
    be_t         mbuf[$];
    logic [31:0] mem_q[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] w_log[$];
    mode_t       mode;
    logic [31:0] m_pc;
    bit          resp_hold;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_log(input string name, input logic [31:0] q[$], input int idx,
                             input logic [31:0] exp);
        checks++;
        if (idx >= q.size()) begin
            failures++;
            $display("FAIL %s actual=missing(entries=%0d) required=%h", name, q.size(), exp);
        end else if (q[idx] !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, q[idx], exp);
        end
    endtask

    // One clock: present memory response, compare DUT to model, advance model.
    task automatic cycle();
        bit  exp_rv, hs, pop, any_stale;
        int  old_n;
        fl_t e;
        be_t b;
        if (!resp_hold && mem_q.size() > 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = mem_q.pop_front();
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = '0;
        end
        #1;
        if (!reset) begin
            inflight.delete();
            mbuf.delete();
            mode = M_IDLE;
            m_pc = 32'h0;
            check("rst_req_valid", mem_req_valid, 0);
            check("rst_req_addr", mem_req_addr, 32'h0);
            check("rst_instr_valid", instr_valid, 0);
            check("rst_instr_data", instr_data, 32'h0);
            check("rst_instr_pc", instr_pc, 32'h0);
        end else begin
            exp_rv = (mode == M_FETCH) && fetch_en && !redirect_valid &&
                     (inflight.size() + mbuf.size() < DEPTH);
            check("req_valid", mem_req_valid, exp_rv);
            check("req_addr", mem_req_addr, m_pc);
            check("instr_valid", instr_valid, mbuf.size() > 0);
            if (mbuf.size() > 0) begin
                check("instr_pc", instr_pc, mbuf[0].pc);
                check("instr_data", instr_data, mbuf[0].data);
            end
            hs  = exp_rv && mem_req_ready;
            pop = (mbuf.size() > 0) && instr_ready && !redirect_valid;
            old_n = inflight.size();
            if (hs) begin
                mem_q.push_back(m_pc);
                req_log.push_back(m_pc);
            end
            if (pop) begin
                b = mbuf.pop_front();
                pop_log.push_back(b.pc);
            end
            if (mem_resp_valid && inflight.size() > 0) begin
                e = inflight.pop_front();
                if (!e.stale && !redirect_valid) mbuf.push_back('{e.addr, mem_resp_data});
            end
            if (redirect_valid) begin
                mbuf.delete();
                foreach (inflight[i]) inflight[i].stale = 1'b1;
                m_pc = redirect_pc;
                mode = (inflight.size() > 0) ? M_FLUSH : (fetch_en ? M_FETCH : M_IDLE);
            end else begin
                if (hs) begin
                    inflight.push_back('{m_pc, 1'b0});
                    m_pc = m_pc + 32'd4;
                end
                case (mode)
                    M_IDLE:  if (fetch_en) mode = M_FETCH;
                    M_FETCH: if (!fetch_en && old_n == 0) mode = M_IDLE;
                    M_FLUSH: begin
                        any_stale = 1'b0;
                        foreach (inflight[i]) if (inflight[i].stale) any_stale = 1'b1;
                        if (!any_stale) mode = fetch_en ? M_FETCH : M_IDLE;
                    end
                    default: mode = M_IDLE;
                endcase
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drain();
        fetch_en = 0; redirect_valid = 0; instr_ready = 1; mem_req_ready = 1; resp_hold = 0;
        repeat (8) cycle();
    endtask

    task automatic clear_logs();
        req_log.delete();
        pop_log.delete();
    endtask

    initial begin
        reset = 0; fetch_en = 0; redirect_valid = 0; redirect_pc = '0;
        mem_req_ready = 0; instr_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        resp_hold = 0; mode = M_IDLE; m_pc = '0;
        w_reset = 0; w_fetch_en = 0; w_mem_req_ready = 0;
        @(negedge clock);
        repeat (2) cycle();
        reset = 1;

        // sequential fetch with 1-cycle memory
        fetch_en = 1; instr_ready = 1; mem_req_ready = 1;
        repeat (8) cycle();
        for (int i = 0; i < 4; i++) begin
            check_log("t1_req_addr", req_log, i, 32'(i * 4));
            check_log("t1_pop_pc", pop_log, i, 32'(i * 4));
        end

        // credit limit under decode backpressure
        drain();
        clear_logs();
        instr_ready = 0; fetch_en = 1;
        repeat (10) cycle();
        check("t2_req_count", req_log.size(), 4);
        check("t2_stalled_valid", mem_req_valid, 0);
        instr_ready = 1;
        cycle();
        instr_ready = 0;
        repeat (5) cycle();
        check("t2_req_after_pop", req_log.size(), 5);

        // redirect with 3 stale requests in flight
        drain();
        clear_logs();
        resp_hold = 1; instr_ready = 0; fetch_en = 1;
        repeat (4) cycle();
        check("t3_outstanding", req_log.size(), 3);
        clear_logs();
        redirect_valid = 1; redirect_pc = 32'h100;
        cycle();
        redirect_valid = 0; resp_hold = 0; instr_ready = 1;
        repeat (10) cycle();
        check_log("t3_first_req", req_log, 0, 32'h100);
        check_log("t3_first_pop", pop_log, 0, 32'h100);
        check_log("t3_second_pop", pop_log, 1, 32'h104);

        // redirect over a non-empty buffer with a response in the redirect cycle
        drain();
        instr_ready = 0; fetch_en = 1;
        repeat (4) cycle();
        check("t3b_buf_full", instr_valid, 1);
        clear_logs();
        redirect_valid = 1; redirect_pc = 32'h200;
        cycle();
        redirect_valid = 0;
        check("t3b_buf_cleared", instr_valid, 0);
        instr_ready = 1;
        repeat (6) cycle();
        check_log("t3b_first_req", req_log, 0, 32'h200);
        check_log("t3b_first_pop", pop_log, 0, 32'h200);

        // held responses released in the redirect cycle, then back-to-back redirects
        drain();
        resp_hold = 1; instr_ready = 0; fetch_en = 1;
        repeat (4) cycle();
        clear_logs();
        resp_hold = 0;
        redirect_valid = 1; redirect_pc = 32'h300;
        cycle();
        redirect_pc = 32'h400;
        cycle();
        redirect_valid = 0; instr_ready = 1;
        repeat (8) cycle();
        check_log("t3c_first_req", req_log, 0, 32'h400);
        check_log("t3c_first_pop", pop_log, 0, 32'h400);

        // memory backpressure holds the address
        drain();
        redirect_valid = 1; redirect_pc = 32'h500;
        cycle();
        redirect_valid = 0;
        clear_logs();
        mem_req_ready = 0; fetch_en = 1;
        repeat (6) cycle();
        check("t4_valid_held", mem_req_valid, 1);
        check("t4_addr_held", mem_req_addr, 32'h500);
        check("t4_no_handshake", req_log.size(), 0);
        mem_req_ready = 1;
        cycle();
        check_log("t4_first_req", req_log, 0, 32'h500);
        check("t4_addr_next", mem_req_addr, 32'h504);

        // reset with 2 requests outstanding
        drain();
        clear_logs();
        resp_hold = 1; fetch_en = 1;
        repeat (3) cycle();
        check("t6_outstanding", req_log.size(), 2);
        reset = 0;
        resp_hold = 0;
        repeat (3) cycle();
        reset = 1;
        clear_logs();
        instr_ready = 1; mem_req_ready = 1;
        repeat (6) cycle();
        check_log("t6_first_req", req_log, 0, 32'h0);
        check_log("t6_first_pop", pop_log, 0, 32'h0);
        check_log("t6_second_pop", pop_log, 1, 32'h4);

        // PC wrap from RESET_PC=0xFFFFFFFC
        drain();
        check("t5_rst_addr", w_mem_req_addr, 32'hFFFF_FFFC);
        check("t5_rst_valid", w_mem_req_valid, 0);
        w_reset = 1; w_fetch_en = 1; w_mem_req_ready = 1;
        for (int i = 0; i < 6; i++) begin
            if (w_mem_req_valid && w_mem_req_ready) w_log.push_back(w_mem_req_addr);
            @(posedge clock);
            @(negedge clock);
        end
        check_log("t5_req0", w_log, 0, 32'hFFFF_FFFC);
        check_log("t5_req1_wrap", w_log, 1, 32'h0000_0000);
        check_log("t5_req2", w_log, 2, 32'h0000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
